// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a 4-to-1 data-select mux: steps sel 0..3, settles TICK_DIV cycles per channel, samples y.
// Latency: frame_valid rises 4*(TICK_DIV+1)+1 cycles after start is taken in IDLE.
// Backpressure: frame/frame_valid held in HOLD until frame_ready; start ignored while busy.
// Optional: define MUX_SCAN_AUTORESTART_EN to rescan continuously after each handshake.
module mux_scan_sequencer #(
  parameter int TICK_DIV = 4,  // settle cycles per channel, 1..255
  parameter int CNT_W    = 8   // settle counter width, 2**CNT_W > TICK_DIV
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       y,
  output logic [1:0] sel,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    HOLD
  } state_t;

  // Last settle count: SETTLE spans counts 0..TICK_DIV-1, i.e. exactly TICK_DIV cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  // Channels 0..2 are buffered here; channel 3 goes straight from y into frame.
  logic [2:0]       shadow;

  // Scan FSM with all outputs registered; reset discards any partial frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sel         <= 2'd0;
      cnt         <= '0;
      shadow      <= 3'd0;
      frame       <= 4'd0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= SETTLE;
            sel    <= 2'd0;
            cnt    <= '0;
            shadow <= 3'd0;
            busy   <= 1'b1;
          end
        end

        SETTLE: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state <= SAMPLE;
          end
        end

        SAMPLE: begin
          case (sel)
            2'd0: shadow[0] <= y;
            2'd1: shadow[1] <= y;
            2'd2: shadow[2] <= y;
            default: begin
              frame       <= {y, shadow};
              frame_valid <= 1'b1;
            end
          endcase
          if (sel == 2'd3) begin
            // sel stays at 3 through HOLD; it never wraps inside a scan.
            state <= HOLD;
          end else begin
            sel   <= sel + 2'd1;
            cnt   <= '0;
            state <= SETTLE;
          end
        end

        HOLD: begin
          if (frame_ready) begin
            frame_valid <= 1'b0;
`ifdef MUX_SCAN_AUTORESTART_EN
            state  <= SETTLE;
            sel    <= 2'd0;
            cnt    <= '0;
            shadow <= 3'd0;
`else
            state <= IDLE;
            busy  <= 1'b0;
`endif
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: two instances (TICK_DIV=4 and TICK_DIV=1) each driven by a mux model.
// Cycle n of a test is the clock period that ends with posedge n; cycle 0 carries the start pulse.
// Inputs change 1ns after a posedge, outputs are checked on the following negedge.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, start1;
  logic [3:0] d, d1;
  logic       y, y1;
  logic [1:0] sel, sel1;
  logic [3:0] frame, frame1;
  logic       frame_valid, frame_valid1;
  logic       frame_ready, frame_ready1;
  logic       busy, busy1;

  int errors = 0;
  int checks = 0;

  // Combinational mux models feeding each sequencer.
  assign y  = d[sel];
  assign y1 = d1[sel1];

  always #5 clk = ~clk;

  mux_scan_sequencer #(.TICK_DIV(4), .CNT_W(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .y(y), .sel(sel),
    .frame(frame), .frame_valid(frame_valid), .frame_ready(frame_ready), .busy(busy)
  );

  mux_scan_sequencer #(.TICK_DIV(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .y(y1), .sel(sel1),
    .frame(frame1), .frame_valid(frame_valid1), .frame_ready(frame_ready1), .busy(busy1)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves the bench 1ns into cycle 1 with start dropped again.
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_start1();
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    start1       = 1'b0;
    d            = 4'b0000;
    d1           = 4'b0000;
    frame_ready  = 1'b0;
    frame_ready1 = 1'b0;

    // Reset values, then 50 idle cycles with start low.
    #1;
    check("rst_sel", sel, 0);
    check("rst_frame", frame, 0);
    check("rst_valid", frame_valid, 0);
    check("rst_busy", busy, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c % 10 == 0) begin
        check($sformatf("idle_sel_c%0d", c), sel, 0);
        check($sformatf("idle_frame_c%0d", c), frame, 0);
        check($sformatf("idle_valid_c%0d", c), frame_valid, 0);
        check($sformatf("idle_busy_c%0d", c), busy, 0);
      end
    end

`ifdef MUX_SCAN_AUTORESTART_EN
    // Continuous scanning after one start: valid pulses every 21 cycles.
    d = 4'b0110;
    frame_ready = 1'b1;
    pulse_start();
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      check($sformatf("ar_valid_c%0d", c), frame_valid, (c == 21 || c == 42 || c == 63) ? 1 : 0);
      check($sformatf("ar_busy_c%0d", c), busy, 1);
      if (c == 21 || c == 42 || c == 63) check($sformatf("ar_frame_c%0d", c), frame, 4'b0110);
      if (c == 22 || c == 43) check($sformatf("ar_sel_c%0d", c), sel, 0);
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    check("ar_rst_busy", busy, 0);
    check("ar_rst_valid", frame_valid, 0);
    check("ar_rst_sel", sel, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ar_idle_busy", busy, 0);
`else
    // Single scan with ready already high.
    d = 4'b1010;
    frame_ready = 1'b1;
    pulse_start();
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      check($sformatf("ss_valid_c%0d", c), frame_valid, (c == 21) ? 1 : 0);
      if (c <= 20) check($sformatf("ss_sel_c%0d", c), sel, (c - 1) / 5);
      if (c == 21) check("ss_frame", frame, 4'b1010);
      check($sformatf("ss_busy_c%0d", c), busy, (c <= 21) ? 1 : 0);
      @(posedge clk); #1;
    end

    // Backpressure: ready low until cycle 40, d changes at 25, stray start at 30.
    frame_ready = 1'b0;
    pulse_start();
    for (int c = 1; c <= 45; c++) begin
      if (c == 25) d = 4'b0101;
      if (c == 30) start = 1'b1;
      if (c == 31) start = 1'b0;
      if (c == 40) frame_ready = 1'b1;
      @(negedge clk);
      check($sformatf("bp_valid_c%0d", c), frame_valid, (c >= 21 && c <= 40) ? 1 : 0);
      if (c >= 21) check($sformatf("bp_frame_c%0d", c), frame, 4'b1010);
      if (c >= 16 && c <= 40) check($sformatf("bp_sel_c%0d", c), sel, 3);
      check($sformatf("bp_busy_c%0d", c), busy, (c <= 40) ? 1 : 0);
      @(posedge clk); #1;
    end

    // Reset in cycle 12 of a scan, then a clean scan of 0001.
    d = 4'b1111;
    pulse_start();
    for (int c = 1; c < 12; c++) begin
      @(posedge clk); #1;
    end
    check("mr_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    check("mr_sel", sel, 0);
    check("mr_busy", busy, 0);
    check("mr_valid", frame_valid, 0);
    check("mr_frame", frame, 0);
    @(negedge clk);
    reset_n = 1'b1;
    d = 4'b0001;
    pulse_start();
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      check($sformatf("mr2_valid_c%0d", c), frame_valid, (c == 21) ? 1 : 0);
      if (c == 21) check("mr2_frame", frame, 4'b0001);
      @(posedge clk); #1;
    end

    // Minimum divider on the TICK_DIV=1 instance.
    d1 = 4'b1111;
    frame_ready1 = 1'b1;
    pulse_start1();
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      check($sformatf("md_valid_c%0d", c), frame_valid1, (c == 9) ? 1 : 0);
      if (c <= 8) check($sformatf("md_sel_c%0d", c), sel1, (c - 1) / 2);
      if (c == 9) check("md_frame", frame1, 4'b1111);
      check($sformatf("md_busy_c%0d", c), busy1, (c <= 9) ? 1 : 0);
      @(posedge clk); #1;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
